scan_sequencer_3b: RTL and testbench
====================================

Name: scan_sequencer_3b

Overview:
- Time-multiplexed channel sequencer that drives the 3-bit select and enable inputs of the 3x8 one-hot decoder stage (decoder `in_i` <- `sel_o`, decoder `enable` <- `enable_o`).
- Steps through eight channels, holding each for a programmable dwell period, with optional blanking gaps so the select never changes while the decoder is enabled.
- Supports continuous scanning, single-stepping and per-channel skip masking. Used for display-digit and LED-matrix scanning.

Parameters:
- DWELL_CYCLES, 4, cycles `enable_o` stays high per channel visit; legal range 1..255.
- BLANK_CYCLES, 1, cycles `enable_o` stays low between consecutive visits in run mode; legal range 0..255 (0 = no gap).

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- run_i  input  1  level; 1 = scan continuously.
- step_i  input  1  single-cycle pulse; one visit to the next channel, honoured only in IDLE with run_i=0.
- mask_i  input  8  channel enable mask; bit n=1 means channel n is visited.
- sel_o  output  3  channel index, to decoder `in_i`.
- enable_o  output  1  decoder enable.
- wrap_o  output  1  one-cycle pulse when the sequence wraps.
- busy_o  output  1  1 whenever the state is not IDLE.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low.
- Reset values: sel_o=3'b111, enable_o=0, wrap_o=0, busy_o=0, state=IDLE, counters=0. These apply immediately on rst_ni falling, including mid-DWELL or mid-BLANK. Operation resumes on the first clock edge after rst_ni rises.
- All outputs are registered.
- next(c): the lowest-indexed set bit of mask_i strictly after c, searching c+1..7 then 0..c, so c itself is the last candidate. It is undefined when mask_i=0, and that case never advances.
- States: IDLE, DWELL, BLANK.
- IDLE:
  - enable_o=0; sel_o holds.
  - Edge with run_i=1 and mask_i!=0: next cycle is DWELL, sel_o=next(sel_o), run mode.
  - Else edge with step_i=1 and mask_i!=0: same transition, but single-step mode.
  - mask_i=0: stay IDLE; run_i and step_i are ignored.
  - run_i has priority over step_i.
- DWELL:
  - enable_o=1 for exactly DWELL_CYCLES consecutive cycles; sel_o is stable throughout.
  - Decision is made on the last dwell cycle.
  - Single-step mode, or run_i=0, or mask_i=0: go to IDLE (enable_o=0 next cycle, sel_o holds).
  - Else if BLANK_CYCLES>0: go to BLANK, sel_o=next(sel_o) loaded on BLANK entry.
  - Else: next cycle is DWELL with sel_o=next(sel_o). enable_o stays 1 and only sel_o changes.
  - run_i dropping early in the dwell does not shorten the dwell.
  - step_i is ignored outside IDLE.
- BLANK:
  - enable_o=0 for BLANK_CYCLES cycles, then DWELL on the already-loaded sel_o.
  - run_i=0 on any BLANK cycle: go to IDLE next cycle. sel_o keeps the loaded channel, so the next run/step resumes after it.
- wrap_o: asserted for exactly one cycle, aligned with the first DWELL cycle of a visit whose sel_o is less than or equal to the previous sel_o. This applies in any mode.
  - The first visit after reset (7 -> 0) wraps.
  - With a single unmasked channel, every visit wraps.
- Mask sampling: mask_i is sampled only at advance points (IDLE exit and the last DWELL cycle). Clearing the current channel's bit mid-dwell does not truncate the visit.
- Latency: run_i or step_i sampled at edge k gives enable_o=1 and a valid sel_o from edge k+1.
- Run-mode period per visit is DWELL_CYCLES+BLANK_CYCLES. A full 8-channel scan with all bits set takes 8x that.

Test Plan (DWELL_CYCLES=4, BLANK_CYCLES=1):
- Reset release, mask_i=8'hFF, run_i=1: sel_o goes 0,1,...,7,0. Each visit has 4 cycles of enable_o=1 then 1 cycle of 0. wrap_o pulses on the first cycle of channel 0, every 40 cycles. busy_o=1 throughout.
- mask_i=8'b1010_0100, run_i=1: sel_o visits only 2,5,7,2,... wrap_o pulses on each entry to 2. enable_o is never high while sel_o changes.
- run_i=0, mask_i=8'hFF, sel_o=3, one step_i pulse: sel_o=4, enable_o=1 for exactly 4 cycles, then IDLE with sel_o=4 and busy_o=0. A second pulse gives sel_o=5. A step_i pulse during DWELL is ignored.
- BLANK_CYCLES=0 build, mask_i=8'hFF, run_i=1: enable_o stays constantly 1 and sel_o increments every 4 cycles. Drop run_i on dwell cycle 2: the dwell completes its 4 cycles, then enable_o=0.
- rst_ni driven low asynchronously mid-DWELL on channel 6: sel_o=7 and enable_o=0 immediately, without a clock. After release with run_i=1, scanning restarts at channel 0 with a wrap_o pulse.
- mask_i=0 with run_i=1: state stays IDLE, enable_o=0. Set mask_i=8'h01 while running: every visit is channel 0, and wrap_o pulses on every visit.

Source files
------------

// File: rtl/scan_sequencer_3b_if.sv
// Bus interface between a scan controller and scan_sequencer_3b.
//   run_i    : level, 1 = scan continuously
//   step_i   : single-cycle pulse, one visit (IDLE with run_i=0 only)
//   mask_i   : channel enable mask, bit n=1 visits channel n
//   sel_o    : channel index to the decoder select input
//   enable_o : decoder enable
//   wrap_o   : one-cycle pulse on the first dwell cycle of a wrapping visit
//   busy_o   : 1 whenever the sequencer is not idle
interface scan_sequencer_3b_if;
  logic       run_i;
  logic       step_i;
  logic [7:0] mask_i;
  logic [2:0] sel_o;
  logic       enable_o;
  logic       wrap_o;
  logic       busy_o;

  modport slave (
    input  run_i, step_i, mask_i,
    output sel_o, enable_o, wrap_o, busy_o
  );

  modport master (
    output run_i, step_i, mask_i,
    input  sel_o, enable_o, wrap_o, busy_o
  );
endinterface

// File: rtl/scan_sequencer_3b.sv
// Time-multiplexed 8-channel scan sequencer driving a 3x8 decoder.
// Holds each unmasked channel for DWELL_CYCLES with enable high, with an
// optional BLANK_CYCLES gap so the select never moves while enabled.
//   clk_i  : system clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : scan_sequencer_3b_if.slave (run/step/mask in, sel/enable/wrap/busy out)
module scan_sequencer_3b #(
  parameter int unsigned DWELL_CYCLES = 4,
  parameter int unsigned BLANK_CYCLES = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  scan_sequencer_3b_if.slave   bus
);

  localparam int unsigned CNT_W      = 8;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST =
    (BLANK_CYCLES == 0) ? '0 : CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    BLANK = 2'd2
  } state_e;

  state_e           state_q;
  logic [2:0]       sel_q;
  logic             enable_q;
  logic             wrap_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic             step_mode_q;
  logic             wrap_pend_q;

  logic [2:0]       next_sel;
  logic             mask_any;
  logic             next_wraps;

  // Lowest set mask bit strictly after c, wrapping; c itself is last candidate.
  function automatic logic [2:0] next_ch(input logic [2:0] c, input logic [7:0] m);
    logic [2:0] r;
    logic [2:0] idx;
    r = c;
    for (int i = 8; i >= 1; i--) begin
      idx = c + 3'(i);
      if (m[idx]) r = idx;
    end
    return r;
  endfunction

  assign next_sel   = next_ch(sel_q, bus.mask_i);
  assign mask_any   = |bus.mask_i;
  assign next_wraps = (next_sel <= sel_q);

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      sel_q       <= 3'b111;
      enable_q    <= 1'b0;
      wrap_q      <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      step_mode_q <= 1'b0;
      wrap_pend_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (mask_any && (bus.run_i || bus.step_i)) begin
            state_q     <= DWELL;
            sel_q       <= next_sel;
            wrap_q      <= next_wraps;
            enable_q    <= 1'b1;
            busy_q      <= 1'b1;
            cnt_q       <= '0;
            step_mode_q <= !bus.run_i;
          end
        end
        DWELL: begin
          if (cnt_q == DWELL_LAST) begin
            cnt_q <= '0;
            if (step_mode_q || !bus.run_i || !mask_any) begin
              state_q  <= IDLE;
              enable_q <= 1'b0;
              busy_q   <= 1'b0;
            end else if (BLANK_CYCLES > 0) begin
              // Load the next channel now; its wrap flag fires on DWELL entry.
              state_q     <= BLANK;
              sel_q       <= next_sel;
              wrap_pend_q <= next_wraps;
              enable_q    <= 1'b0;
            end else begin
              sel_q  <= next_sel;
              wrap_q <= next_wraps;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        BLANK: begin
          if (!bus.run_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == BLANK_LAST) begin
            state_q  <= DWELL;
            enable_q <= 1'b1;
            wrap_q   <= wrap_pend_q;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q  <= IDLE;
          enable_q <= 1'b0;
          busy_q   <= 1'b0;
          cnt_q    <= '0;
        end
      endcase
    end
  end

  assign bus.sel_o    = sel_q;
  assign bus.enable_o = enable_q;
  assign bus.wrap_o   = wrap_q;
  assign bus.busy_o   = busy_q;

endmodule

// File: tb/tb_scan_sequencer_3b.sv
module tb_scan_sequencer_3b;

  logic clk;
  logic rsta_n;
  logic rstb_n;

  int passed;
  int failed;
  int total;

  scan_sequencer_3b_if ifa ();
  scan_sequencer_3b_if ifb ();

  scan_sequencer_3b #(.DWELL_CYCLES(4), .BLANK_CYCLES(1)) dut_a (
    .clk_i  (clk),
    .rst_ni (rsta_n),
    .bus    (ifa)
  );

  scan_sequencer_3b #(.DWELL_CYCLES(4), .BLANK_CYCLES(0)) dut_b (
    .clk_i  (clk),
    .rst_ni (rstb_n),
    .bus    (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [2:0] s, input logic e,
                       input logic w, input logic b);
    chk({tag, ".sel"},  32'(ifa.sel_o),    32'(s));
    chk({tag, ".en"},   32'(ifa.enable_o), 32'(e));
    chk({tag, ".wrap"}, 32'(ifa.wrap_o),   32'(w));
    chk({tag, ".busy"}, 32'(ifa.busy_o),   32'(b));
  endtask

  task automatic step_a();
    ifa.step_i = 1'b1;
    cyc(1);
    ifa.step_i = 1'b0;
  endtask

  int chs [5] = '{2, 5, 7, 2, 5};
  int wrs [5] = '{1, 0, 0, 1, 0};

  initial begin
    passed = 0; failed = 0; total = 0;
    rsta_n = 1'b0; rstb_n = 1'b0;
    ifa.run_i = 1'b0; ifa.step_i = 1'b0; ifa.mask_i = 8'hFF;
    ifb.run_i = 1'b0; ifb.step_i = 1'b0; ifb.mask_i = 8'hFF;
    cyc(2);

    // Reset state
    chk_a("reset", 3'd7, 1'b0, 1'b0, 1'b0);

    // Full scan, all channels, run mode
    ifa.run_i = 1'b1;
    rsta_n = 1'b1;
    cyc(1);
    for (int v = 0; v < 9; v++) begin
      for (int j = 0; j < 5; j++) begin
        if (j < 4) chk_a("scan_dwell", 3'(v), 1'b1, (j == 0) && (v % 8 == 0), 1'b1);
        else       chk_a("scan_blank", 3'(v + 1), 1'b0, 1'b0, 1'b1);
        cyc(1);
      end
    end

    // Async reset mid-dwell on channel 6
    cyc(26);
    chk_a("pre_rst_ch6", 3'd6, 1'b1, 1'b0, 1'b1);
    #2 rsta_n = 1'b0;
    #1 chk_a("async_rst", 3'd7, 1'b0, 1'b0, 1'b0);

    // Masked scan 2,5,7
    @(negedge clk);
    ifa.mask_i = 8'b1010_0100;
    rsta_n = 1'b1;
    cyc(1);
    for (int v = 0; v < 4; v++) begin
      for (int j = 0; j < 5; j++) begin
        if (j < 4) chk_a("mask_dwell", 3'(chs[v]), 1'b1, (j == 0) && (wrs[v] == 1), 1'b1);
        else       chk_a("mask_blank", 3'(chs[v + 1]), 1'b0, 1'b0, 1'b1);
        cyc(1);
      end
    end

    // Single-step: walk to channel 3 first
    ifa.run_i = 1'b0;
    rsta_n = 1'b0;
    cyc(1);
    ifa.mask_i = 8'hFF;
    rsta_n = 1'b1;
    cyc(1);
    for (int k = 0; k < 4; k++) begin
      step_a();
      chk_a("walk_step", 3'(k), 1'b1, k == 0, 1'b1);
      cyc(5);
    end
    chk_a("idle_at3", 3'd3, 1'b0, 1'b0, 1'b0);

    step_a();
    for (int j = 0; j < 4; j++) begin
      chk_a("step4_dwell", 3'd4, 1'b1, 1'b0, 1'b1);
      if (j == 1) ifa.step_i = 1'b1;
      if (j == 2) ifa.step_i = 1'b0;
      cyc(1);
    end
    chk_a("step4_done", 3'd4, 1'b0, 1'b0, 1'b0);
    cyc(2);
    chk_a("step4_hold", 3'd4, 1'b0, 1'b0, 1'b0);
    step_a();
    chk_a("step5", 3'd5, 1'b1, 1'b0, 1'b1);
    cyc(6);

    // Empty mask: never leaves IDLE; then single channel 0
    rsta_n = 1'b0;
    cyc(1);
    ifa.mask_i = 8'h00;
    ifa.run_i = 1'b1;
    rsta_n = 1'b1;
    cyc(5);
    chk_a("mask0_idle", 3'd7, 1'b0, 1'b0, 1'b0);
    ifa.mask_i = 8'h01;
    cyc(1);
    for (int v = 0; v < 3; v++) begin
      for (int j = 0; j < 5; j++) begin
        chk_a("single_ch", 3'd0, j < 4, j == 0, 1'b1);
        cyc(1);
      end
    end
    ifa.run_i = 1'b0;

    // No-blank build: enable stays high, select advances every 4 cycles
    ifb.run_i = 1'b1;
    rstb_n = 1'b1;
    cyc(1);
    for (int t = 0; t < 16; t++) begin
      chk("nb.sel",  32'(ifb.sel_o),    32'(t / 4));
      chk("nb.en",   32'(ifb.enable_o), 32'd1);
      chk("nb.wrap", 32'(ifb.wrap_o),   32'(t == 0));
      chk("nb.busy", 32'(ifb.busy_o),   32'd1);
      cyc(1);
    end
    cyc(1);
    chk("nb_c1.sel", 32'(ifb.sel_o), 32'd4);
    ifb.run_i = 1'b0;
    cyc(1);
    chk("nb_c2.en",  32'(ifb.enable_o), 32'd1);
    chk("nb_c2.sel", 32'(ifb.sel_o),    32'd4);
    cyc(1);
    chk("nb_c3.en",  32'(ifb.enable_o), 32'd1);
    cyc(1);
    chk("nb_stop.en",   32'(ifb.enable_o), 32'd0);
    chk("nb_stop.sel",  32'(ifb.sel_o),    32'd4);
    chk("nb_stop.busy", 32'(ifb.busy_o),   32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
